sd_spi_responder: RTL and testbench
===================================

SD_SPI_RESPONDER -- requirements
Module: sd_spi_responder

Interface
REQ-001 SHALL have parameter NCR_MIN, default 1, minimum whole 0xFF bytes on miso between command end bit and response byte.
REQ-002 SHALL have parameter RESP_TIMEOUT, default 8, maximum 0xFF bytes waited for resp_valid before abandoning the command.
REQ-003 SHALL have port clk  input  1  system clock, at least 4x sclk frequency.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port sclk  input  1  SPI clock from host (SD[2]).
REQ-006 SHALL have port cs_n  input  1  chip select, active low (SD[7]).
REQ-007 SHALL have port mosi  input  1  command data from host (SD[3]).
REQ-008 SHALL have port miso  output  1  response data to host (SD[4]).
REQ-009 SHALL have port cmd_valid  output  1  one-clk pulse, command captured.
REQ-010 SHALL have port cmd_index  output  6  command index, stable from cmd_valid until the next cmd_valid.
REQ-011 SHALL have port cmd_arg  output  32  command argument, same stability as cmd_index.
REQ-012 SHALL have port resp_byte  input  8  R1 byte to return.
REQ-013 SHALL have port resp_valid  input  1  resp_byte valid; honoured only in WAIT_RESP.
REQ-014 SHALL have port timeout  output  1  one-clk pulse when RESP_TIMEOUT expires.

Function
REQ-015 SHALL pass sclk, cs_n and mosi through 2-flop synchronizers and detect sclk rising and falling edges from the synchronized value.
REQ-016 SHALL implement SPI mode 0: mosi sampled on sclk rising edge, miso updated on sclk falling edge, MSB first.
REQ-017 SHALL use states IDLE, CMD, WAIT_RESP, RESP.
REQ-018 IDLE: a sampled 0 followed by a sampled 1 (start and transmission bits) SHALL enter CMD; other bits are ignored.
REQ-019 CMD: SHALL shift the remaining 46 bits; on the 48th bit SHALL leave CMD for WAIT_RESP.
REQ-020 A frame whose end bit is 0 SHALL be discarded silently (no cmd_valid) and return to IDLE.
REQ-021 cmd_valid SHALL assert exactly one clk after the clk in which the end-bit rising edge is detected.
REQ-022 WAIT_RESP: miso SHALL be 1; bytes are counted on falling-edge byte boundaries.
REQ-023 resp_byte SHALL be latched on resp_valid; its transmission SHALL start at the first byte boundary after both the latch and NCR_MIN bytes have elapsed.
REQ-024 If RESP_TIMEOUT bytes elapse with no latch, SHALL pulse timeout and return to IDLE; a later resp_valid SHALL be ignored.
REQ-025 RESP: SHALL drive the 8 response bits, then return to IDLE with miso = 1.
REQ-026 When cs_n is high (synchronized), SHALL force IDLE and miso = 1 regardless of state; a partial frame SHALL produce no cmd_valid.
REQ-027 Any sclk edge arriving while cs_n is high SHALL be ignored.
REQ-028 A new start bit that arrives during WAIT_RESP or RESP SHALL be ignored.

Reset
REQ-029 While reset_n is low: state IDLE, miso = 1, cmd_valid = 0, timeout = 0, cmd_index = 0, cmd_arg = 0, all counters and shift registers cleared.
REQ-030 Reset deassertion mid-frame SHALL resume in IDLE, hunting a fresh start bit.

Configuration
REQ-031 With macro SD_SPI_CRC_CHECK_EN defined, SHALL compute CRC7 (polynomial x^7+x^3+1) over the first 40 frame bits and compare it with bits [7:1].
REQ-032 On a CRC mismatch, SHALL suppress cmd_valid and send R1 = 0x08 (com CRC error) under the REQ-023 timing, without waiting for resp_valid.
REQ-033 Without SD_SPI_CRC_CHECK_EN, the CRC field SHALL be ignored and no CRC logic instantiated.

Structure
REQ-034 Package sd_spi_pkg SHALL hold: the state enum, CMD_FRAME_BITS = 48, R1_IDLE = 8'h01, R1_ILLEGAL_CMD = 8'h04, R1_CRC_ERR = 8'h08, CRC7_POLY = 7'h09.
REQ-035 SHALL instantiate the sub-module sd_crc7 (serial CRC7, bit-enable plus clear), only when SD_SPI_CRC_CHECK_EN is defined.

Verification
REQ-036 CMD0 frame 40 00 00 00 00 95 -> one cmd_valid with index 0 and arg 0; resp_byte 0x01 given at once -> miso shows FF then 01, then stays high.
REQ-037 CMD17 frame 51 00 00 02 00 with correct CRC, resp_valid held off 3 bytes -> miso FF FF FF then resp_byte; cmd_arg = 0x00000200.
REQ-038 With SD_SPI_CRC_CHECK_EN, CMD0 frame sent with CRC byte 0x00 -> no cmd_valid; miso FF then 08.
REQ-039 cs_n raised after 20 bits of a frame -> no cmd_valid, miso = 1; an immediately following full CMD8 (48 00 00 01 AA 87) is decoded correctly.
REQ-040 No resp_valid for 8 bytes -> timeout pulses once and state returns to IDLE; resp_valid pulsed afterwards -> miso remains 1.
REQ-041 reset_n pulsed low during RESP -> miso = 1 asynchronously; the next CMD0 frame is handled normally.

Source files
------------

// File: rtl/sd_spi_pkg.sv
// SD SPI-mode responder shared types: FSM states, frame/R1 constants, serial CRC7 step.
// Package only: no latency, no backpressure.
package sd_spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WAIT_RESP,
    RESP
  } state_t;

  localparam int         CMD_FRAME_BITS = 48;
  localparam logic [7:0] R1_IDLE        = 8'h01;
  localparam logic [7:0] R1_ILLEGAL_CMD = 8'h04;
  localparam logic [7:0] R1_CRC_ERR     = 8'h08;
  localparam logic [6:0] CRC7_POLY      = 7'h09;

  // One MSB-first bit of x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator: one bit per en_i, clr_i zeroes it (clr wins).
// Latency: crc_o reflects a bit one clk after en_i; no backpressure.
module sd_crc7 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       din_i,
  output logic [6:0] crc_o
);
  import sd_spi_pkg::*;

  logic [6:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr_i) begin
      crc_d = '0;
    end else if (en_i) begin
      crc_d = crc7_step(crc_q, din_i);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/sd_spi_responder.sv
// SD SPI-mode (mode 0) command responder: captures 48-bit frames, returns one R1 byte; optional CRC7 check under SD_SPI_CRC_CHECK_EN.
// Latency: cmd_valid 1 clk after the end-bit edge; no backpressure (host-clocked), response waits up to RESP_TIMEOUT bytes.
module sd_spi_responder #(
  parameter int NCR_MIN      = 1,
  parameter int RESP_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  input  logic [7:0]  resp_byte,
  input  logic        resp_valid,
  output logic        timeout
);
  import sd_spi_pkg::*;

  localparam int               CNT_W    = 16;
  localparam logic [CNT_W-1:0] NCR_CNT  = CNT_W'(NCR_MIN);
  localparam logic [CNT_W-1:0] TMO_CNT  = CNT_W'(RESP_TIMEOUT);
  localparam logic [5:0]       LAST_BIT = 6'(CMD_FRAME_BITS - 1);

  logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic cs_meta_q, cs_sync_q;
  logic mosi_meta_q, mosi_sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_prev_q <= 1'b0;
      cs_meta_q   <= 1'b1;
      cs_sync_q   <= 1'b1;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      sclk_meta_q <= sclk;
      sclk_sync_q <= sclk_meta_q;
      sclk_prev_q <= sclk_sync_q;
      cs_meta_q   <= cs_n;
      cs_sync_q   <= cs_meta_q;
      mosi_meta_q <= mosi;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  // Edges seen while deselected never reach the FSM.
  logic sclk_rise, sclk_fall;
  assign sclk_rise = !cs_sync_q && sclk_sync_q && !sclk_prev_q;
  assign sclk_fall = !cs_sync_q && !sclk_sync_q && sclk_prev_q;

  state_t            state_q, state_d;
  logic              zero_seen_q, zero_seen_d;
  logic [5:0]        bit_cnt_q, bit_cnt_d;
  logic [44:0]       cmd_sr_q, cmd_sr_d;
  logic [5:0]        cmd_index_q, cmd_index_d;
  logic [31:0]       cmd_arg_q, cmd_arg_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              timeout_q, timeout_d;
  logic [7:0]        resp_q, resp_d;
  logic              latched_q, latched_d;
  logic [2:0]        phase_q, phase_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]        tx_q, tx_d;
  logic              latch_now;
  logic [7:0]        resp_now;
  logic              start_hit;
  logic              crc_ok;

  assign start_hit = (state_q == IDLE) && sclk_rise && zero_seen_q && mosi_sync_q;

  always_comb begin
    state_d     = state_q;
    zero_seen_d = zero_seen_q;
    bit_cnt_d   = bit_cnt_q;
    cmd_sr_d    = cmd_sr_q;
    cmd_index_d = cmd_index_q;
    cmd_arg_d   = cmd_arg_q;
    cmd_valid_d = 1'b0;
    timeout_d   = 1'b0;
    resp_d      = resp_q;
    latched_d   = latched_q;
    phase_d     = phase_q;
    byte_cnt_d  = byte_cnt_q;
    tx_d        = tx_q;
    latch_now   = latched_q || resp_valid;
    resp_now    = latched_q ? resp_q : resp_byte;

    unique case (state_q)
      IDLE: begin
        if (start_hit) begin
          state_d     = CMD;
          bit_cnt_d   = 6'd2;
          zero_seen_d = 1'b0;
        end else if (sclk_rise) begin
          zero_seen_d = !mosi_sync_q;
        end
      end

      CMD: begin
        if (sclk_rise) begin
          cmd_sr_d  = {cmd_sr_q[43:0], mosi_sync_q};
          bit_cnt_d = bit_cnt_q + 6'd1;
          // cmd_sr_q holds frame bits [45:1] here; mosi_sync_q is the end bit.
          if (bit_cnt_q == LAST_BIT) begin
            phase_d    = 3'd7;
            byte_cnt_d = '0;
            latched_d  = 1'b0;
            if (!crc_ok) begin
              state_d   = WAIT_RESP;
              resp_d    = R1_CRC_ERR;
              latched_d = 1'b1;
            end else if (!mosi_sync_q) begin
              state_d = IDLE;
            end else begin
              state_d     = WAIT_RESP;
              cmd_valid_d = 1'b1;
              cmd_index_d = cmd_sr_q[44:39];
              cmd_arg_d   = cmd_sr_q[38:7];
            end
          end
        end
      end

      WAIT_RESP: begin
        if (resp_valid && !latched_q) begin
          resp_d    = resp_byte;
          latched_d = 1'b1;
        end
        // phase_q == 7 marks the falling edge that closes a byte.
        if (sclk_fall) begin
          if (phase_q != 3'd7) begin
            phase_d = phase_q + 3'd1;
          end else if (latch_now && (byte_cnt_q >= NCR_CNT)) begin
            state_d = RESP;
            tx_d    = resp_now;
            phase_d = 3'd0;
          end else if (!latch_now && (byte_cnt_q >= TMO_CNT)) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
          end else begin
            phase_d = 3'd0;
            if (byte_cnt_q != '1) begin
              byte_cnt_d = byte_cnt_q + CNT_W'(1);
            end
          end
        end
      end

      RESP: begin
        if (sclk_fall) begin
          if (phase_q == 3'd7) begin
            state_d = IDLE;
          end else begin
            phase_d = phase_q + 3'd1;
            tx_d    = {tx_q[6:0], 1'b1};
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (cs_sync_q) begin
      state_d     = IDLE;
      zero_seen_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      zero_seen_q <= 1'b0;
      bit_cnt_q   <= '0;
      cmd_sr_q    <= '0;
      cmd_index_q <= '0;
      cmd_arg_q   <= '0;
      cmd_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      resp_q      <= '0;
      latched_q   <= 1'b0;
      phase_q     <= '0;
      byte_cnt_q  <= '0;
      tx_q        <= '0;
    end else begin
      state_q     <= state_d;
      zero_seen_q <= zero_seen_d;
      bit_cnt_q   <= bit_cnt_d;
      cmd_sr_q    <= cmd_sr_d;
      cmd_index_q <= cmd_index_d;
      cmd_arg_q   <= cmd_arg_d;
      cmd_valid_q <= cmd_valid_d;
      timeout_q   <= timeout_d;
      resp_q      <= resp_d;
      latched_q   <= latched_d;
      phase_q     <= phase_d;
      byte_cnt_q  <= byte_cnt_d;
      tx_q        <= tx_d;
    end
  end

`ifdef SD_SPI_CRC_CHECK_EN
  localparam logic [5:0] CRC_BITS = 6'(CMD_FRAME_BITS - 8);

  logic       crc_clr, crc_en;
  logic [6:0] crc_val;

  // A leading start bit leaves a cleared CRC at zero, so feeding starts at the transmission bit.
  assign crc_clr = (state_q == IDLE) && !start_hit;
  assign crc_en  = start_hit || ((state_q == CMD) && sclk_rise && (bit_cnt_q < CRC_BITS));

  sd_crc7 u_crc7 (
    .clk    (clk),
    .reset_n(reset_n),
    .clr_i  (crc_clr),
    .en_i   (crc_en),
    .din_i  (mosi_sync_q),
    .crc_o  (crc_val)
  );

  assign crc_ok = (cmd_sr_q[6:0] == crc_val);
`else
  assign crc_ok = 1'b1;
`endif

  assign miso      = (state_q == RESP) ? tx_q[7] : 1'b1;
  assign cmd_valid = cmd_valid_q;
  assign cmd_index = cmd_index_q;
  assign cmd_arg   = cmd_arg_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_sd_spi_responder.sv
// Bench for sd_spi_responder: host-side SPI driver with queued expectations for commands and miso bytes.
// Covers CMD0/CMD8/CMD17, bad end bit, bad CRC, aborted frame, response timeout and reset mid-response.
module tb_sd_spi_responder;

  localparam int HALF = 80;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sclk;
  logic        cs_n;
  logic        mosi;
  logic        miso;
  logic        cmd_valid;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [7:0]  resp_byte;
  logic        resp_valid;
  logic        timeout;

  int n_tests = 0;
  int n_fail  = 0;
  int timeouts = 0;
  logic cv_prev = 1'b0;
  logic [37:0] exp_cmd_q[$];
  logic [7:0]  exp_miso_q[$];
  logic [37:0] e;

  always #5 clk = ~clk;

  sd_spi_responder #(
    .NCR_MIN     (1),
    .RESP_TIMEOUT(8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .cmd_valid (cmd_valid),
    .cmd_index (cmd_index),
    .cmd_arg   (cmd_arg),
    .resp_byte (resp_byte),
    .resp_valid(resp_valid),
    .timeout   (timeout)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmd_valid) begin
      check("cmd_width", cv_prev, 0);
      if (exp_cmd_q.size() == 0) begin
        check("cmd_unexpected", cmd_valid, 0);
      end else begin
        e = exp_cmd_q.pop_front();
        check("cmd_index", cmd_index, e[37:32]);
        check("cmd_arg", cmd_arg, e[31:0]);
      end
    end
    cv_prev = cmd_valid;
    if (timeout) timeouts++;
  end

  function automatic logic [47:0] mk_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] d;
    logic [6:0]  c;
    logic        fb;
    d = {2'b01, idx, arg};
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return {d, c, 1'b1};
  endfunction

  task automatic spi_bit(input logic b, output logic r);
    mosi = b;
    #HALF;
    r = miso;
    sclk = 1'b1;
    #HALF;
    sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], r);
      rx[i] = r;
    end
    #HALF;
  endtask

  task automatic send_frame(input logic [47:0] f);
    logic [7:0] rx;
    for (int b = 5; b >= 0; b--) begin
      spi_byte(f[8*b +: 8], rx);
      check("miso_during_cmd", rx, 8'hFF);
    end
  endtask

  task automatic read_bytes(input int n);
    logic [7:0] rx;
    logic [7:0] ex;
    for (int k = 0; k < n; k++) begin
      spi_byte(8'hFF, rx);
      ex = (exp_miso_q.size() != 0) ? exp_miso_q.pop_front() : 8'hFF;
      check("miso_byte", rx, ex);
    end
  endtask

  task automatic pulse_resp(input logic [7:0] b);
    @(negedge clk);
    resp_byte  = b;
    resp_valid = 1'b1;
    @(negedge clk);
    resp_valid = 1'b0;
  endtask

  task automatic cs_cycle();
    cs_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("miso_cs_high", miso, 1);
    cs_n = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    logic       r;
    logic [47:0] f;
    int         t0;

    reset_n    = 1'b0;
    sclk       = 1'b0;
    cs_n       = 1'b1;
    mosi       = 1'b1;
    resp_valid = 1'b0;
    resp_byte  = 8'h00;
    repeat (5) @(posedge clk);
    #1;
    check("rst_miso", miso, 1);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_timeout", timeout, 0);
    check("rst_cmd_index", cmd_index, 0);
    check("rst_cmd_arg", cmd_arg, 0);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    cs_n = 1'b0;
    repeat (4) @(posedge clk);

    // CMD0, response offered immediately
    exp_cmd_q.push_back({6'd0, 32'd0});
    send_frame(48'h400000000095);
    check("cmd0_seen", exp_cmd_q.size(), 0);
    pulse_resp(8'h01);
    exp_miso_q.push_back(8'hFF); exp_miso_q.push_back(8'h01); exp_miso_q.push_back(8'hFF);
    read_bytes(3);
    cs_cycle();

    // CMD17, response held off
    exp_cmd_q.push_back({6'd17, 32'h0000_0200});
    send_frame(mk_frame(6'd17, 32'h0000_0200));
    check("cmd17_seen", exp_cmd_q.size(), 0);
    exp_miso_q.push_back(8'hFF); exp_miso_q.push_back(8'hFF);
    read_bytes(2);
    pulse_resp(8'h5A);
    exp_miso_q.push_back(8'hFF); exp_miso_q.push_back(8'h5A); exp_miso_q.push_back(8'hFF);
    read_bytes(3);
    cs_cycle();

    // CMD0 with a zero CRC byte
    send_frame(48'h400000000000);
`ifdef SD_SPI_CRC_CHECK_EN
    exp_miso_q.push_back(8'hFF); exp_miso_q.push_back(8'h08); exp_miso_q.push_back(8'hFF);
`else
    exp_miso_q.push_back(8'hFF); exp_miso_q.push_back(8'hFF); exp_miso_q.push_back(8'hFF);
`endif
    read_bytes(3);
    cs_cycle();

    // Correct CRC but end bit 0: discarded, later resp_valid ignored
    send_frame(48'h400000000094);
    pulse_resp(8'h01);
    exp_miso_q.push_back(8'hFF); exp_miso_q.push_back(8'hFF); exp_miso_q.push_back(8'hFF);
    read_bytes(3);
    cs_cycle();

    // Frame aborted after 20 bits, then CMD8
    f = mk_frame(6'd17, 32'h0000_0200);
    for (int i = 47; i >= 28; i--) spi_bit(f[i], r);
    cs_cycle();
    exp_cmd_q.push_back({6'd8, 32'h0000_01AA});
    send_frame(48'h48000001AA87);
    check("cmd8_seen", exp_cmd_q.size(), 0);
    pulse_resp(8'hA5);
    exp_miso_q.push_back(8'hFF); exp_miso_q.push_back(8'hA5); exp_miso_q.push_back(8'hFF);
    read_bytes(3);
    cs_cycle();

    // Response timeout
    t0 = timeouts;
    exp_cmd_q.push_back({6'd0, 32'd0});
    send_frame(48'h400000000095);
    for (int k = 0; k < 7; k++) exp_miso_q.push_back(8'hFF);
    read_bytes(7);
    check("timeout_early", timeouts, t0);
    exp_miso_q.push_back(8'hFF);
    read_bytes(1);
    repeat (4) @(posedge clk);
    check("timeout_once", timeouts, t0 + 1);
    pulse_resp(8'h00);
    exp_miso_q.push_back(8'hFF); exp_miso_q.push_back(8'hFF);
    read_bytes(2);
    check("timeout_total", timeouts, t0 + 1);
    cs_cycle();

    // Reset during RESP
    exp_cmd_q.push_back({6'd8, 32'h0000_01AA});
    send_frame(48'h48000001AA87);
    pulse_resp(8'h01);
    exp_miso_q.push_back(8'hFF);
    read_bytes(1);
    check("miso_resp_bit7", miso, 0);
    for (int i = 0; i < 3; i++) spi_bit(1'b1, r);
    #3;
    reset_n = 1'b0;
    #1;
    check("rst_async_miso", miso, 1);
    check("rst_async_arg", cmd_arg, 0);
    check("rst_async_index", cmd_index, 0);
    repeat (3) @(posedge clk);
    reset_n = 1'b1;
    cs_cycle();
    exp_cmd_q.push_back({6'd0, 32'd0});
    send_frame(48'h400000000095);
    pulse_resp(8'h01);
    exp_miso_q.push_back(8'hFF); exp_miso_q.push_back(8'h01); exp_miso_q.push_back(8'hFF);
    read_bytes(3);
    cs_cycle();

    check("cmd_q_empty", exp_cmd_q.size(), 0);
    check("miso_q_empty", exp_miso_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
